int_regfile_sb: RTL and testbench
=================================

Name: int_regfile_sb

Overview:
Integer register file with an issue scoreboard. It consumes the decoder's read_addr_a/read_addr_b/write_addr/int_write_enable outputs at issue, and holds each instruction until its source and destination registers have no write-back pending. It then marks the destination busy until the execute/write-back stage returns data. It provides the two read-operand ports and the single write port of the integer pipeline.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (x0 included)
AW, 5, register address width; NREG == 2**AW

Ports:
clk_i  input  1  clock; all state updates on rising edge
rsn_i  input  1  reset; asynchronous, active-high
issue_valid_i  input  1  decoded instruction present at issue
issue_read_addr_a_i  input  AW  source register A from decoder
issue_read_addr_b_i  input  AW  source register B from decoder
issue_write_addr_i  input  AW  destination register from decoder
issue_write_enable_i  input  1  destination is written (decoder int_write_enable)
stall_o  input->output  1  issue must hold; instruction not accepted this cycle
read_data_a_o  output  XLEN  operand A
read_data_b_o  output  XLEN  operand B
wb_valid_i  input  1  write-back this cycle
wb_addr_i  input  AW  write-back destination
wb_data_i  input  XLEN  write-back data
flush_i  input  1  pipeline flush; drop all pending reservations
busy_count_o  output  AW+1  number of registers currently busy
wb_err_o  output  1  sticky: write-back to a non-busy register seen

Behaviour:
- Clock and reset: one clock (clk_i); reset rsn_i is asynchronous and active-high.
- Reset: all registers 0, all busy bits 0, busy_count_o=0, wb_err_o=0, stall_o=0.
- x0: always reads 0. It is never marked busy. Writes to it are ignored, and a wb to x0 does not set wb_err_o.
- Reads are combinational with write-back bypass: if wb_valid_i && wb_addr_i==addr && addr!=0, the output is wb_data_i; otherwise the output is the array value.
- Effective busy: busy_eff[r] = busy[r] && !(wb_valid_i && wb_addr_i==r).
- stall_o = issue_valid_i && !flush_i && (busy_eff[a] || busy_eff[b] || (issue_write_enable_i && busy_eff[wd])). This checks RAW on both sources and WAW on the destination.
- Source checks apply whatever the opcode. The decoder does not qualify source use, so a spurious stall is acceptable and correct.
- Accept: issue_valid_i && !stall_o. On accept with issue_write_enable_i && wd!=0, busy[wd] is set at the next edge.
- Write-back at the edge, when wb_valid_i && wb_addr_i!=0:
  - reg[wb_addr_i] <= wb_data_i.
  - busy[wb_addr_i] is cleared.
  - If busy[wb_addr_i] was 0 before the edge, wb_err_o is set to 1. It stays 1 until reset.
- Simultaneous accept setting r and wb clearing r: set wins, and r remains busy. This is legal because busy_eff allowed the accept.
- Flush: flush_i forces stall_o=0, no accept occurs, and all busy bits clear at the edge. A register write-back in the same cycle still updates the array, and wb_err_o is not set for that cycle.
- busy_count_o is a registered popcount of busy. It is updated at the same edge as busy and lies between 0 and NREG-1.
- Latency: issue-to-busy is 1 cycle; write-back is visible on reads in the same cycle (bypass) and from the array in the next cycle.
- Reset asserted mid-operation clears all state immediately; outstanding write-backs after reset count as errors.

Test Plan:
- Reset then read: after rsn_i pulse, read x5, x31 -> read_data 0, stall_o=0, busy_count_o=0, wb_err_o=0.
- Issue/RAW stall:
  - Stimulus: issue wd=3 we=1 accepted; next cycle issue a=3, no wb.
  - Required: stall_o=1 and busy_count_o=1.
  - Then wb_valid addr=3 data=0xDEADBEEF: same cycle stall_o=0 and read_data_a_o=0xDEADBEEF; next cycle busy_count_o=0.
- WAW plus same-cycle set/clear:
  - Stimulus: x7 busy; issue wd=7 while wb addr=7 data=0x11.
  - Required: stall_o=0; after edge busy[7]=1, reg7=0x11, busy_count_o=1.
- x0 handling: issue wd=0 we=1, then wb addr=0 data=0xFF -> busy_count_o=0, reads of x0 = 0, wb_err_o=0.
- Flush:
  - Stimulus: mark x1, x2, x4 busy (busy_count_o=3); assert flush_i with issue a=1 and wb addr=4 data=0x44.
  - Required: stall_o=0; next cycle busy_count_o=0, reg4=0x44, wb_err_o=0.
- Spurious wb: wb addr=9 data=0x5 with x9 not busy -> reg9=0x5, wb_err_o=1, and it stays 1 until rsn_i.

Source files
------------

// File: rtl/int_regfile_sb.sv
// -----------------------------------------------------------------------------
// int_regfile_sb
//   Integer register file with an issue scoreboard. An instruction at issue is
//   held (stall_o) while either source register or its destination has a
//   write-back pending. Once it is accepted, its destination is marked busy
//   until the write-back port returns data for it. Reads are combinational and
//   bypass a same-cycle write-back.
//
// Ports
//   clk_i                 clock, rising edge
//   rsn_i                 asynchronous active-high reset
//   issue_valid_i         decoded instruction present at issue
//   issue_read_addr_a_i   source register A
//   issue_read_addr_b_i   source register B
//   issue_write_addr_i    destination register
//   issue_write_enable_i  destination is written
//   stall_o               instruction not accepted this cycle
//   read_data_a_o         operand A
//   read_data_b_o         operand B
//   wb_valid_i            write-back this cycle
//   wb_addr_i             write-back destination
//   wb_data_i             write-back data
//   flush_i               drop all pending reservations
//   busy_count_o          number of busy registers (registered)
//   wb_err_o              sticky: write-back to a non-busy register seen
// -----------------------------------------------------------------------------
module int_regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            issue_valid_i,
    input  logic [AW-1:0]   issue_read_addr_a_i,
    input  logic [AW-1:0]   issue_read_addr_b_i,
    input  logic [AW-1:0]   issue_write_addr_i,
    input  logic            issue_write_enable_i,
    output logic            stall_o,
    output logic [XLEN-1:0] read_data_a_o,
    output logic [XLEN-1:0] read_data_b_o,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic [AW:0]     busy_count_o,
    output logic            wb_err_o
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busy_count;
    logic            r_wb_err;

    logic            w_wb_reg;     // write-back to a real register (not x0)
    logic [NREG-1:0] w_wb_hit;     // one-hot of the register being written back
    logic [NREG-1:0] w_busy_eff;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_accept;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NREG; i++) begin
            n = n + {{AW{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wb_reg = wb_valid_i && (wb_addr_i != '0);
        w_wb_hit = '0;
        if (w_wb_reg) begin
            w_wb_hit[wb_addr_i] = 1'b1;
        end

        // A register being written back this cycle is already free for issue.
        w_busy_eff = r_busy & ~w_wb_hit;

        stall_o = issue_valid_i && !flush_i &&
                  (w_busy_eff[issue_read_addr_a_i] ||
                   w_busy_eff[issue_read_addr_b_i] ||
                   (issue_write_enable_i && w_busy_eff[issue_write_addr_i]));

        w_accept = issue_valid_i && !stall_o && !flush_i;

        w_set = '0;
        if (w_accept && issue_write_enable_i && (issue_write_addr_i != '0)) begin
            w_set[issue_write_addr_i] = 1'b1;
        end

        // Clear before set: a same-cycle reservation of the register being
        // written back keeps it busy for the new producer.
        w_busy_nxt = flush_i ? '0 : ((r_busy & ~w_wb_hit) | w_set);

        // x0 reads as zero regardless of bypass; otherwise bypass, then array.
        if (issue_read_addr_a_i == '0) begin
            read_data_a_o = '0;
        end else if (w_wb_hit[issue_read_addr_a_i]) begin
            read_data_a_o = wb_data_i;
        end else begin
            read_data_a_o = r_regs[issue_read_addr_a_i];
        end

        if (issue_read_addr_b_i == '0) begin
            read_data_b_o = '0;
        end else if (w_wb_hit[issue_read_addr_b_i]) begin
            read_data_b_o = wb_data_i;
        end else begin
            read_data_b_o = r_regs[issue_read_addr_b_i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            // NOTE: the register array is reset explicitly because software may
            // read any register before writing it and must see zero.
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
            r_wb_err     <= 1'b0;
        end else begin
            if (w_wb_reg) begin
                r_regs[wb_addr_i] <= wb_data_i;
            end
            r_busy       <= w_busy_nxt;
            r_busy_count <= popcount(w_busy_nxt);
            // A flush cancels the reservations, so a write-back racing it is
            // not treated as an orphan.
            if (w_wb_reg && !r_busy[wb_addr_i] && !flush_i) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign busy_count_o = r_busy_count;
    assign wb_err_o     = r_wb_err;

endmodule

// File: tb/tb_int_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_int_regfile_sb
//   Directed scenarios followed by a randomized run against a behavioural
//   scoreboard model (register values, per-register busy flags, sticky error).
// -----------------------------------------------------------------------------
module tb_int_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic            issue_valid;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   rb;
    logic [AW-1:0]   wd;
    logic            we;
    logic            stall;
    logic [XLEN-1:0] rda;
    logic [XLEN-1:0] rdb;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [AW:0]     busy_count;
    logic            wb_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_reg  [NREG];
    bit          m_busy [NREG];
    bit          m_err;

    int_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk_i                (clk),
        .rsn_i                (rst),
        .issue_valid_i        (issue_valid),
        .issue_read_addr_a_i  (ra),
        .issue_read_addr_b_i  (rb),
        .issue_write_addr_i   (wd),
        .issue_write_enable_i (we),
        .stall_o              (stall),
        .read_data_a_o        (rda),
        .read_data_b_o        (rdb),
        .wb_valid_i           (wb_valid),
        .wb_addr_i            (wb_addr),
        .wb_data_i            (wb_data),
        .flush_i              (flush),
        .busy_count_o         (busy_count),
        .wb_err_o             (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    task automatic idle();
        issue_valid = 0; ra = 0; rb = 0; wd = 0; we = 0;
        wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0;
    endtask

    task automatic set_issue(input bit v, input int a, input int b, input int d, input bit e);
        issue_valid = v; ra = AW'(a); rb = AW'(b); wd = AW'(d); we = e;
    endtask

    task automatic set_wb(input bit v, input int addr, input logic [XLEN-1:0] data);
        wb_valid = v; wb_addr = AW'(addr); wb_data = data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    // --------------------------------------------------------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_issue(1, 5, 31, 9, 1);
        #1;
        checks++; if (rda !== 32'h0) begin failures++; $display("FAIL reset_read_x5 got=%h exp=%h", rda, 32'h0); end
        checks++; if (rdb !== 32'h0) begin failures++; $display("FAIL reset_read_x31 got=%h exp=%h", rdb, 32'h0); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL reset_busy_count got=%0d exp=0", busy_count); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
        set_issue(0, 0, 0, 0, 0);
        do_reset();
    endtask

    task automatic test_raw_stall();
        @(negedge clk);
        idle();
        set_issue(1, 0, 0, 3, 1);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_first_issue_stall got=%b exp=0", stall); end
        @(negedge clk);
        set_issue(1, 3, 0, 0, 0);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b exp=1", stall); end
        checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL raw_busy_count got=%0d exp=1", busy_count); end
        set_wb(1, 3, 32'hDEADBEEF);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_wb_release_stall got=%b exp=0", stall); end
        checks++; if (rda !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_bypass got=%h exp=%h", rda, 32'hDEADBEEF); end
        @(negedge clk);
        idle();
        set_issue(0, 0, 3, 0, 0);
        #1;
        checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL raw_busy_count_after got=%0d exp=0", busy_count); end
        checks++; if (rdb !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_array_read got=%h exp=%h", rdb, 32'hDEADBEEF); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL raw_wb_err got=%b exp=0", wb_err); end
    endtask

    task automatic test_waw_same_cycle();
        @(negedge clk);
        idle();
        set_issue(1, 0, 0, 7, 1);
        @(negedge clk);
        set_issue(1, 0, 0, 7, 1);
        set_wb(1, 7, 32'h11);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL waw_stall got=%b exp=0", stall); end
        @(negedge clk);
        idle();
        set_issue(1, 7, 0, 0, 0);
        #1;
        checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL waw_busy_count got=%0d exp=1", busy_count); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_still_busy got=%b exp=1", stall); end
        checks++; if (rda !== 32'h11) begin failures++; $display("FAIL waw_reg7 got=%h exp=%h", rda, 32'h11); end
        set_wb(1, 7, 32'h22);
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL waw_drain got=%0d exp=0", busy_count); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL waw_wb_err got=%b exp=0", wb_err); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle();
        set_issue(1, 0, 0, 0, 1);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_issue_stall got=%b exp=0", stall); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL x0_busy_count got=%0d exp=0", busy_count); end
        set_wb(1, 0, 32'hFF);
        #1;
        checks++; if (rda !== 32'h0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", rda); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rda !== 32'h0) begin failures++; $display("FAIL x0_read got=%h exp=0", rda); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL x0_wb_err got=%b exp=0", wb_err); end
        checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL x0_busy_after_wb got=%0d exp=0", busy_count); end
    endtask

    task automatic test_flush();
        @(negedge clk); idle(); set_issue(1, 0, 0, 1, 1);
        @(negedge clk); idle(); set_issue(1, 0, 0, 2, 1);
        @(negedge clk); idle(); set_issue(1, 0, 0, 4, 1);
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", busy_count); end
        flush = 1;
        set_issue(1, 1, 0, 5, 1);
        set_wb(1, 4, 32'h44);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
        @(negedge clk);
        idle();
        set_issue(1, 4, 2, 0, 0);
        #1;
        checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL flush_busy_count got=%0d exp=0", busy_count); end
        checks++; if (rda !== 32'h44) begin failures++; $display("FAIL flush_reg4 got=%h exp=%h", rda, 32'h44); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_cleared_stall got=%b exp=0", stall); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL flush_wb_err got=%b exp=0", wb_err); end
        set_issue(0, 0, 0, 0, 0);
    endtask

    task automatic test_spurious_wb();
        @(negedge clk);
        idle();
        set_wb(1, 9, 32'h5);
        @(negedge clk);
        idle();
        set_issue(0, 9, 0, 0, 0);
        #1;
        checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL spurious_wb_err got=%b exp=1", wb_err); end
        checks++; if (rda !== 32'h5) begin failures++; $display("FAIL spurious_reg9 got=%h exp=%h", rda, 32'h5); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL spurious_sticky got=%b exp=1", wb_err); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        idle();
        set_issue(1, 0, 0, 6, 1);
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=1", busy_count); end
        rst = 1'b1;
        #1;
        checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL midrst_async_count got=%0d exp=0", busy_count); end
        checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL midrst_async_err got=%b exp=0", wb_err); end
        #1;
        rst = 1'b0;
        @(negedge clk);
        set_wb(1, 6, 32'h66);
        @(negedge clk);
        idle();
        #1;
        checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL midrst_orphan_wb got=%b exp=1", wb_err); end
    endtask

    // ----------------------------------------------------------- random model
    function automatic bit m_free_now(input int r);
        // Register r counts as available if it is not reserved, or if its
        // result arrives this very cycle.
        return !m_busy[r] || (wb_valid && int'(wb_addr) == r);
    endfunction

    function automatic bit m_stall();
        if (!issue_valid || flush) return 0;
        if (!m_free_now(int'(ra))) return 1;
        if (!m_free_now(int'(rb))) return 1;
        if (we && !m_free_now(int'(wd))) return 1;
        return 0;
    endfunction

    function automatic int unsigned m_read(input int r);
        if (r == 0) return 0;
        if (wb_valid && int'(wb_addr) == r) return wb_data;
        return m_reg[r];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic test_random();
        int          exp_cnt;
        bit          accepted;
        int          pick;
        int unsigned exp_a;
        int unsigned exp_b;
        bit          exp_s;
        do_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = 0;
            m_busy[i] = 0;
        end
        m_err = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 1) == 1);
            // Mostly return results for registers that are actually pending.
            pick = $urandom_range(0, 7);
            if ($urandom_range(0, 9) < 8) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_busy[(pick + k) % 8]) begin
                        pick = (pick + k) % 8;
                        break;
                    end
                end
            end
            set_wb($urandom_range(0, 2) != 0, pick, $urandom());
            flush = ($urandom_range(0, 39) == 0);
            #1;
            exp_s = m_stall();
            exp_a = m_read(int'(ra));
            exp_b = m_read(int'(rb));
            checks++; if (stall !== exp_s) begin failures++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, stall, exp_s); end
            checks++; if (rda !== exp_a) begin failures++; $display("FAIL rand_read_a cyc=%0d addr=%0d got=%h exp=%h", cyc, ra, rda, exp_a); end
            checks++; if (rdb !== exp_b) begin failures++; $display("FAIL rand_read_b cyc=%0d addr=%0d got=%h exp=%h", cyc, rb, rdb, exp_b); end
            // Model update for the coming edge.
            accepted = issue_valid && !exp_s && !flush;
            if (wb_valid && wb_addr != 0) begin
                if (!m_busy[wb_addr] && !flush) m_err = 1;
                m_reg[wb_addr] = wb_data;
                m_busy[wb_addr] = 0;
            end
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 0;
            end else if (accepted && we && wd != 0) begin
                m_busy[wd] = 1;
            end
            @(posedge clk);
            #1;
            exp_cnt = m_count();
            checks++; if (int'(busy_count) != exp_cnt) begin failures++; $display("FAIL rand_busy_count cyc=%0d got=%0d exp=%0d", cyc, busy_count, exp_cnt); end
            checks++; if (wb_err !== m_err) begin failures++; $display("FAIL rand_wb_err cyc=%0d got=%b exp=%b", cyc, wb_err, m_err); end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_waw_same_cycle();
        test_x0();
        test_flush();
        test_spurious_wb();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
